// File: rtl/mem_trace_pkg.sv
// Shared types for the trace replay engine: record layout, FSM states and small helpers.
package mem_trace_pkg;
    localparam int NUM_LANES   = 4;
    localparam int ADDR_WIDTH  = 64;
    localparam int DATA_WIDTH  = 64;
    localparam int CYCLE_WIDTH = 64;
    localparam int LANE_CNT_W  = $clog2(NUM_LANES + 1);

    typedef struct packed {
        logic [CYCLE_WIDTH-1:0]               cycle;
        logic [NUM_LANES-1:0]                 mask;
        logic                                 is_store;
        logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr;
        logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [LANE_CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [LANE_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + LANE_CNT_W'(v[i]);
        end
        return n;
    endfunction
endpackage

// File: rtl/mem_trace_player_fifo.sv
// Synchronous record buffer; the head entry is read straight out of the storage registers.
module trace_record_fifo
    import mem_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  trace_rec_t push_rec,
    input  logic       pop,
    output trace_rec_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mem_trace_player.sv
// Cycle-timed trace replay: buffers records, issues each once the cycle counter reaches its timestamp.
// Streams use valid/ready: a beat transfers on a rising edge with both high; the sender holds it stable until then.
module mem_trace_player
    import mem_trace_pkg::*;
#(
    parameter int  FIFO_DEPTH      = 8,
    parameter int  MAX_OUTSTANDING = 16,
    localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            rec_valid,
    output logic                            rec_ready,
    input  logic [CYCLE_WIDTH-1:0]          rec_cycle,
    input  logic [NUM_LANES-1:0]            rec_mask,
    input  logic                            rec_is_store,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] rec_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] rec_data,
    input  logic                            rec_last,
    output logic                            req_valid,
    input  logic                            req_ready,
    output logic [NUM_LANES-1:0]            req_mask,
    output logic                            req_is_store,
    output logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_LANES*DATA_WIDTH-1:0] req_data,
    input  logic                            resp_valid,
    output logic [CYCLE_WIDTH-1:0]          cycle_count,
    output logic [31:0]                     late_count,
    output logic [OUT_W-1:0]                outstanding,
    output logic                            finished,
    output logic                            err_underflow,
    output state_t                          fsm_state
);
    state_t         state;
    trace_rec_t     push_rec;
    trace_rec_t     head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           rec_fire;
    logic           req_fire;
    logic           slot_free;
    logic           pop;
    logic [OUT_W:0] committed;

    assign fsm_state         = state;
    assign push_rec.cycle    = rec_cycle;
    assign push_rec.mask     = rec_mask;
    assign push_rec.is_store = rec_is_store;
    assign push_rec.addr     = rec_addr;
    assign push_rec.data     = rec_data;

    assign rec_ready = (state == RUN) && !fifo_full;
    assign rec_fire  = rec_valid && rec_ready;
    assign req_fire  = req_valid && req_ready;
    assign slot_free = !req_valid || req_ready;

    // A held request is about to become outstanding, so it counts against the cap.
    assign committed = {1'b0, outstanding} + (OUT_W+1)'(req_valid);
    assign pop = ((state == RUN) || (state == DRAIN)) && !fifo_empty && slot_free
                 && (cycle_count >= head.cycle)
                 && (committed < (OUT_W+1)'(MAX_OUTSTANDING));

    trace_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (rec_fire),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cycle_count   <= '0;
            late_count    <= '0;
            outstanding   <= '0;
            finished      <= 1'b0;
            err_underflow <= 1'b0;
            req_valid     <= 1'b0;
            req_mask      <= '0;
            req_is_store  <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    cycle_count <= cycle_count + CYCLE_WIDTH'(1);
                    if (rec_fire && rec_last) state <= DRAIN;
                end
                DRAIN: begin
                    cycle_count <= cycle_count + CYCLE_WIDTH'(1);
                    if (fifo_empty && !req_valid && (outstanding == '0)) begin
                        state    <= DONE;
                        finished <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (req_fire) req_valid <= 1'b0;

            // Zero-mask records are consumed without producing a request.
            if (pop) begin
                if (head.mask != '0) begin
                    req_valid    <= 1'b1;
                    req_mask     <= head.mask;
                    req_is_store <= head.is_store;
                    req_addr     <= head.addr;
                    req_data     <= head.data;
                end
                if ((cycle_count > head.cycle) && (late_count != '1)) begin
                    late_count <= late_count + 32'd1;
                end
            end

            if (req_fire && !resp_valid) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!req_fire && resp_valid) begin
                if (outstanding == '0) err_underflow <= 1'b1;
                else                   outstanding   <= outstanding - OUT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_trace_player.sv
// Directed and randomized replay sessions checked every cycle against a queue-based model of the player.
`timescale 1ns/1ps
module tb_mem_trace_player;
    import mem_trace_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int MAX_OUT    = 16;
    localparam int OUT_W      = $clog2(MAX_OUT + 1);
    localparam int LIMIT      = 2000;

    logic                            clock = 1'b0;
    logic                            reset = 1'b1;
    logic                            start = 1'b0;
    logic                            rec_valid = 1'b0;
    logic                            rec_ready;
    logic [CYCLE_WIDTH-1:0]          rec_cycle = '0;
    logic [NUM_LANES-1:0]            rec_mask = '0;
    logic                            rec_is_store = 1'b0;
    logic [NUM_LANES*ADDR_WIDTH-1:0] rec_addr = '0;
    logic [NUM_LANES*DATA_WIDTH-1:0] rec_data = '0;
    logic                            rec_last = 1'b0;
    logic                            req_valid;
    logic                            req_ready = 1'b0;
    logic [NUM_LANES-1:0]            req_mask;
    logic                            req_is_store;
    logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_LANES*DATA_WIDTH-1:0] req_data;
    logic                            resp_valid = 1'b0;
    logic [CYCLE_WIDTH-1:0]          cycle_count;
    logic [31:0]                     late_count;
    logic [OUT_W-1:0]                outstanding;
    logic                            finished;
    logic                            err_underflow;
    state_t                          fsm_state;

    int vectors = 0;
    int miscompares = 0;

    mem_trace_player #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_cycle     (rec_cycle),
        .rec_mask      (rec_mask),
        .rec_is_store  (rec_is_store),
        .rec_addr      (rec_addr),
        .rec_data      (rec_data),
        .rec_last      (rec_last),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mask      (req_mask),
        .req_is_store  (req_is_store),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .cycle_count   (cycle_count),
        .late_count    (late_count),
        .outstanding   (outstanding),
        .finished      (finished),
        .err_underflow (err_underflow),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no progress within %0d cycles at %0t", name, LIMIT, $time);
    endfunction

    // ---------------- behavioural model ----------------
    trace_rec_t             m_q[$];
    trace_rec_t             m_req;
    trace_rec_t             m_head;
    trace_rec_t             m_in;
    bit                     m_rv = 0;
    bit                     model_ok = 0;
    int                     m_phase = 0;
    int                     m_out = 0;
    logic [CYCLE_WIDTH-1:0] m_cycle = '0;
    logic [31:0]            m_late = '0;
    bit                     m_fin = 0;
    bit                     m_err = 0;
    bit                     m_accept, m_fire, m_issue, m_quiet;

    always @(posedge clock) begin
        if (reset) begin
            m_q.delete();
            m_req = '0;
            m_rv = 0;
            m_phase = 0;
            m_out = 0;
            m_cycle = '0;
            m_late = '0;
            m_fin = 0;
            m_err = 0;
            model_ok = 1;
        end else if (model_ok) begin
            m_accept = (m_phase == 1) && (m_q.size() < FIFO_DEPTH) && rec_valid;
            m_fire   = m_rv && req_ready;
            m_quiet  = (m_q.size() == 0) && !m_rv && (m_out == 0);
            m_issue  = 0;
            if ((m_phase == 1 || m_phase == 2) && m_q.size() > 0) begin
                m_head  = m_q[0];
                m_issue = (m_cycle >= m_head.cycle) && (!m_rv || req_ready)
                          && (m_out + int'(m_rv) < MAX_OUT);
            end
            if (m_fire && !resp_valid) m_out++;
            else if (!m_fire && resp_valid) begin
                if (m_out == 0) m_err = 1;
                else m_out--;
            end
            if (m_fire) m_rv = 0;
            if (m_issue) begin
                m_head = m_q.pop_front();
                if (m_head.mask != 0) begin
                    m_rv = 1;
                    m_req = m_head;
                end
                if (m_cycle > m_head.cycle && m_late != 32'hffff_ffff) m_late++;
            end
            if (m_accept) begin
                m_in.cycle = rec_cycle;
                m_in.mask = rec_mask;
                m_in.is_store = rec_is_store;
                m_in.addr = rec_addr;
                m_in.data = rec_data;
                m_q.push_back(m_in);
            end
            case (m_phase)
                0: if (start) m_phase = 1;
                1: begin
                    m_cycle++;
                    if (m_accept && rec_last) m_phase = 2;
                end
                2: begin
                    m_cycle++;
                    if (m_quiet) begin
                        m_phase = 3;
                        m_fin = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (model_ok) begin
            chk("rec_ready", rec_ready, (m_phase == 1) && (m_q.size() < FIFO_DEPTH));
            chk("req_valid", req_valid, m_rv);
            if (m_rv) begin
                chk("req_mask", req_mask, m_req.mask);
                chk("req_is_store", req_is_store, m_req.is_store);
                chk("req_addr", req_addr, m_req.addr);
                chk("req_data", req_data, m_req.data);
            end
            chk("cycle_count", cycle_count, m_cycle);
            chk("late_count", late_count, m_late);
            chk("outstanding", outstanding, m_out);
            chk("finished", finished, m_fin);
            chk("err_underflow", err_underflow, m_err);
            chk("fsm_state", fsm_state, m_phase);
        end
    end

    // ---------------- response / ready driver ----------------
    int resp_mode = 0;   // 0 manual, 1 fixed 3-cycle latency, 2 random
    bit ready_rand = 0;
    int tick = 0;
    int sched[$];

    always @(negedge clock) begin
        tick++;
        if (reset) sched.delete();
        if (ready_rand) req_ready = ($urandom_range(0, 3) != 0);
        if (resp_mode == 1) begin
            resp_valid = (sched.size() > 0) && (sched[0] == tick);
            if (resp_valid) sched.delete(0);
        end else if (resp_mode == 2) begin
            resp_valid = (m_out > 0) && ($urandom_range(0, 2) == 0);
        end
        if (resp_mode == 1 && req_valid && req_ready) sched.push_back(tick + 3);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        resp_mode = 0;
        ready_rand = 0;
        resp_valid = 0;
        req_ready = 0;
        rec_valid = 0;
        start = 0;
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1;
        @(negedge clock);
        start = 0;
    endtask

    function automatic trace_rec_t mk_rec(input logic [63:0] cyc, input logic [3:0] mask, input logic st);
        trace_rec_t r;
        r.cycle = cyc;
        r.mask = mask;
        r.is_store = st;
        for (int i = 0; i < NUM_LANES; i++) begin
            r.addr[i] = {$urandom, $urandom};
            r.data[i] = {$urandom, $urandom};
        end
        return r;
    endfunction

    task automatic send_rec(input trace_rec_t r, input logic last);
        int n = 0;
        @(negedge clock);
        rec_valid = 1;
        rec_cycle = r.cycle;
        rec_mask = r.mask;
        rec_is_store = r.is_store;
        rec_addr = r.addr;
        rec_data = r.data;
        rec_last = last;
        while (!rec_ready && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        if (!rec_ready) timeout("send_rec");
        @(negedge clock);
        rec_valid = 0;
        rec_last = 0;
    endtask

    task automatic wait_req(input logic level, input string name);
        int n = 0;
        while (req_valid !== level && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        if (req_valid !== level) timeout(name);
    endtask

    task automatic wait_finished();
        int n = 0;
        while (finished !== 1'b1 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        if (finished !== 1'b1) timeout("wait_finished");
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n;

        // reset state
        do_reset();
        chk("reset_state", fsm_state, IDLE);
        chk("reset_rec_ready", rec_ready, 0);
        chk("reset_cycle", cycle_count, 0);
        chk("reset_outstanding", outstanding, 0);

        // basic replay with fixed-latency responses
        req_ready = 1;
        resp_mode = 1;
        pulse_start();
        send_rec(mk_rec(5, 4'b1111, 1'b0), 1'b0);
        send_rec(mk_rec(10, 4'b0011, 1'b1), 1'b1);
        wait_req(1'b1, "first_issue");
        chk("first_issue_cycle", cycle_count, 6);
        wait_req(1'b0, "first_accept");
        wait_req(1'b1, "second_issue");
        chk("second_issue_cycle", cycle_count, 11);
        wait_finished();
        chk("basic_late", late_count, 0);
        chk("basic_finished", finished, 1);

        // backpressure: request held, buffer fills
        do_reset();
        resp_mode = 2;
        pulse_start();
        for (int i = 0; i < 9; i++) send_rec(mk_rec(0, 4'(i + 1), i[0]), 1'b0);
        chk("full_rec_ready", rec_ready, 0);
        chk("held_req_valid", req_valid, 1);
        repeat (7) @(negedge clock);
        chk("held_outstanding", outstanding, 0);
        ready_rand = 1;
        send_rec(mk_rec(0, 4'b0000, 1'b0), 1'b1);
        wait_finished();

        // outstanding cap, then issue and response together
        do_reset();
        req_ready = 1;
        pulse_start();
        for (int i = 0; i < 20; i++) send_rec(mk_rec(0, 4'b0101, 1'b1), 1'b0);
        repeat (4) @(negedge clock);
        chk("cap_outstanding", outstanding, 16);
        chk("cap_req_valid", req_valid, 0);
        resp_valid = 1;
        @(negedge clock);
        resp_valid = 0;
        wait_req(1'b1, "cap_reissue");
        resp_valid = 1;
        @(negedge clock);
        resp_valid = 0;
        chk("cap_fire_and_resp", outstanding, 15);
        resp_mode = 2;
        send_rec(mk_rec(0, 4'b0000, 1'b0), 1'b1);
        wait_finished();

        // late record and bare last marker
        do_reset();
        req_ready = 1;
        resp_mode = 1;
        pulse_start();
        n = 0;
        while (cycle_count < 9 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        send_rec(mk_rec(3, 4'b1000, 1'b0), 1'b0);
        send_rec(mk_rec(20, 4'b0000, 1'b0), 1'b1);
        wait_finished();
        chk("late_count_one", late_count, 1);
        chk("late_outstanding", outstanding, 0);

        // randomized session; a stray start mid-run must be ignored
        do_reset();
        ready_rand = 1;
        resp_mode = 2;
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            send_rec(mk_rec(64'(i * 2 + $urandom_range(0, 8)), 4'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1))), (i == 59));
            if (i == 30) pulse_start();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clock);
        end
        wait_finished();

        // underflow error, then reset while draining
        do_reset();
        req_ready = 1;
        pulse_start();
        send_rec(mk_rec(1000, 4'b1111, 1'b0), 1'b1);
        @(negedge clock);
        chk("drain_state", fsm_state, DRAIN);
        resp_valid = 1;
        @(negedge clock);
        resp_valid = 0;
        chk("underflow_flag", err_underflow, 1);
        chk("underflow_outstanding", outstanding, 0);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("midreset_state", fsm_state, IDLE);
        chk("midreset_rec_ready", rec_ready, 0);
        chk("midreset_err", err_underflow, 0);
        chk("midreset_cycle", cycle_count, 0);
        pulse_start();
        repeat (5) @(negedge clock);
        chk("flushed_no_req", req_valid, 0);
        chk("flushed_rec_ready", rec_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
